// File: rtl/knn_pkg.sv
// Shared KNN definitions: query-state encoding and the all-ones
// distance helper used by the top-K selector and the distance stage.
package knn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_VOTE = 2'd2,
        S_DONE = 2'd3
    } knn_state_e;

    // All ones in the low w bits (w <= 64); slice down to the width needed.
    function automatic logic [63:0] dist_max(input int unsigned w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/knn_topk_cell.sv
// One slot of the top-K insertion chain: distance/type/occupied regs.
// Ports: clk, rst_n, clr_i (clear), ins_i (sample accepted), d_i/t_i
// (sample), prev_*_i (slot i-1 contents), dist_o/type_o/occ_o (slot).
module knn_topk_cell
    import knn_pkg::*;
#(
    parameter int W      = 32,
    parameter int TYPE_W = 3,
    parameter bit FIRST  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              ins_i,
    input  logic [W-1:0]      d_i,
    input  logic [TYPE_W-1:0] t_i,
    input  logic [W-1:0]      prev_dist_i,
    input  logic [TYPE_W-1:0] prev_type_i,
    input  logic              prev_occ_i,
    output logic [W-1:0]      dist_o,
    output logic [TYPE_W-1:0] type_o,
    output logic              occ_o
);

    localparam logic [63:0]  DM64 = dist_max(W);
    localparam logic [W-1:0] DMAX = DM64[W-1:0];

    logic [W-1:0]      dist_q, dist_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic              occ_q, occ_d;
    logic              lt_prev, shift, load;

    // Occupancy, not distance, decides whether a slot is free, so an
    // all-ones sample still lands in an empty slot.
    assign lt_prev = prev_occ_i && (d_i < prev_dist_i);
    assign shift   = !FIRST && lt_prev;
    assign load    = (!occ_q || (d_i < dist_q)) &&
                     (FIRST || (prev_occ_i && !lt_prev));

    always_comb begin
        dist_d = dist_q;
        type_d = type_q;
        occ_d  = occ_q;
        if (clr_i) begin
            dist_d = DMAX;
            type_d = '0;
            occ_d  = 1'b0;
        end else if (ins_i && shift) begin
            dist_d = prev_dist_i;
            type_d = prev_type_i;
            occ_d  = 1'b1;
        end else if (ins_i && load) begin
            dist_d = d_i;
            type_d = t_i;
            occ_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q <= DMAX;
            type_q <= '0;
            occ_q  <= 1'b0;
        end else begin
            dist_q <= dist_d;
            type_q <= type_d;
            occ_q  <= occ_d;
        end
    end

    assign dist_o = dist_q;
    assign type_o = type_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/knn_topk_sort.sv
// Streaming top-K selector: keeps the K nearest samples sorted, slot 0
// nearest. Ports: start/in_* stream input, in_ready, distance_sorted,
// type_sorted, count, valid_sort; class_out only with KNN_VOTE_EN.
module knn_topk_sort
    import knn_pkg::*;
#(
    parameter int K      = 8,
    parameter int W      = 32,
    parameter int TYPE_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_distance,
    input  logic [TYPE_W-1:0]       in_type,
    input  logic                    in_last,
    output logic [W*K-1:0]          distance_sorted,
    output logic [TYPE_W*K-1:0]     type_sorted,
    output logic [$clog2(K+1)-1:0]  count,
`ifdef KNN_VOTE_EN
    output logic [TYPE_W-1:0]       class_out,
`endif
    output logic                    valid_sort
);

    localparam int CW = $clog2(K+1);

    knn_state_e        state_q;
    logic              in_ready_q, valid_q, accept;
    logic [CW-1:0]     count_q;
    logic [W-1:0]      dist_w [K];
    logic [TYPE_W-1:0] type_w [K];
    logic              occ_w  [K];

    // start always wins over a simultaneous sample.
    assign accept = in_valid && in_ready_q && !start;

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic [W-1:0]      pd;
        logic [TYPE_W-1:0] pt;
        logic              po;
        if (i == 0) begin : g_head
            assign pd = '1;
            assign pt = '0;
            assign po = 1'b0;
        end else begin : g_link
            assign pd = dist_w[i-1];
            assign pt = type_w[i-1];
            assign po = occ_w[i-1];
        end
        knn_topk_cell #(
            .W(W), .TYPE_W(TYPE_W), .FIRST(i == 0)
        ) u_cell (
            .clk(clk), .rst_n(rst_n),
            .clr_i(start), .ins_i(accept),
            .d_i(in_distance), .t_i(in_type),
            .prev_dist_i(pd), .prev_type_i(pt), .prev_occ_i(po),
            .dist_o(dist_w[i]), .type_o(type_w[i]), .occ_o(occ_w[i])
        );
        assign distance_sorted[(i+1)*W-1 -: W]   = dist_w[i];
        assign type_sorted[(i+1)*TYPE_W-1 -: TYPE_W] = type_w[i];
    end

`ifdef KNN_VOTE_EN
    localparam int NCLS = 1 << TYPE_W;

    logic [CW-1:0]     vcnt_q [NCLS];
    logic [CW-1:0]     vidx_q;
    logic [TYPE_W-1:0] class_q, vtype, best;
    logic [CW-1:0]     maxv;
    logic              found;

    always_comb begin
        vtype = '0;
        for (int i = 0; i < K; i++)
            if (CW'(i) == vidx_q) vtype = type_w[i];
    end

    // Nearest slot whose class reaches the top vote breaks ties.
    always_comb begin
        maxv  = '0;
        best  = '0;
        found = 1'b0;
        for (int c = 0; c < NCLS; c++)
            if (vcnt_q[c] > maxv) maxv = vcnt_q[c];
        for (int i = 0; i < K; i++)
            if (!found && occ_w[i] && vcnt_q[type_w[i]] == maxv) begin
                best  = type_w[i];
                found = 1'b1;
            end
    end

    assign class_out = class_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
`ifdef KNN_VOTE_EN
            vidx_q     <= '0;
            class_q    <= '0;
            for (int c = 0; c < NCLS; c++) vcnt_q[c] <= '0;
`endif
        end else if (start) begin
            state_q    <= S_FILL;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            count_q    <= '0;
`ifdef KNN_VOTE_EN
            vidx_q     <= '0;
            class_q    <= '0;
            for (int c = 0; c < NCLS; c++) vcnt_q[c] <= '0;
`endif
        end else begin
            unique case (state_q)
                S_FILL: begin
                    if (accept) begin
                        if (!occ_w[K-1]) count_q <= count_q + 1'b1;
                        if (in_last) begin
                            in_ready_q <= 1'b0;
`ifdef KNN_VOTE_EN
                            state_q    <= S_VOTE;
                            vidx_q     <= '0;
`else
                            state_q    <= S_DONE;
                            valid_q    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KNN_VOTE_EN
                S_VOTE: begin
                    if (vidx_q < count_q) begin
                        vcnt_q[vtype] <= vcnt_q[vtype] + 1'b1;
                        vidx_q        <= vidx_q + 1'b1;
                    end else begin
                        class_q <= best;
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign valid_sort = valid_q;
    assign count      = count_q;

endmodule

// File: tb/tb_knn_topk_sort.sv
// Self-checking bench for knn_topk_sort (K=8, W=32, TYPE_W=3).
// Optional KNN_VOTE_EN build also exercises the class vote.
module tb_knn_topk_sort;

    localparam int K  = 8;
    localparam int W  = 32;
    localparam int TW = 3;
    localparam int CW = $clog2(K+1);

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
    } smp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [W-1:0]    in_distance = '0;
    logic [TW-1:0]   in_type = '0;
    logic            in_ready;
    logic [W*K-1:0]  distance_sorted;
    logic [TW*K-1:0] type_sorted;
    logic [CW-1:0]   count;
    logic            valid_sort;
`ifdef KNN_VOTE_EN
    logic [TW-1:0]   class_out;
`endif

    smp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    knn_topk_sort #(.K(K), .W(W), .TYPE_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_distance(in_distance), .in_type(in_type), .in_last(in_last),
        .distance_sorted(distance_sorted), .type_sorted(type_sorted),
        .count(count),
`ifdef KNN_VOTE_EN
        .class_out(class_out),
`endif
        .valid_sort(valid_sort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int done_lat(input int n);
`ifdef KNN_VOTE_EN
        return n + 1;
`else
        return 0;
`endif
    endfunction

    task automatic do_start(input bit with_sample);
        start = 1'b1;
        if (with_sample) begin
            in_valid = 1'b1;
            in_distance = 32'd7;
            in_type = 3'd6;
        end
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("start.ready", in_ready, 1);
        chk("start.valid", valid_sort, 0);
        chk("start.count", count, 0);
        chk("start.slot0", distance_sorted[W-1:0], 32'hFFFF_FFFF);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t,
                        input bit last);
        in_valid = 1'b1;
        in_distance = d;
        in_type = t;
        in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        sb_q.push_back('{d: d, t: t});
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (!valid_sort && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
    endtask

    // Stable selection of the K smallest queued samples, then drain.
    task automatic check_list(input string tag);
        int   n = sb_q.size();
        bit   taken[];
        smp_t e;
        int   best;
        taken = new[n];
        chk({tag, ".count"}, count, (n < K) ? n : K);
        chk({tag, ".valid"}, valid_sort, 1);
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int j = 0; j < n; j++)
                if (!taken[j] && (best < 0 || sb_q[j].d < sb_q[best].d))
                    best = j;
            if (best >= 0) begin
                e = sb_q[best];
                taken[best] = 1'b1;
            end else begin
                e = '{d: 32'hFFFF_FFFF, t: 3'd0};
            end
            chk($sformatf("%s.d%0d", tag, k), distance_sorted[k*W +: W], e.d);
            chk($sformatf("%s.t%0d", tag, k), type_sorted[k*TW +: TW], e.t);
        end
        while (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    initial begin
        logic [W-1:0] r;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dist", distance_sorted, {(W*K){1'b1}});
        chk("rst.type", type_sorted, 0);
        chk("rst.count", count, 0);
        chk("rst.valid", valid_sort, 0);
        chk("rst.ready", in_ready, 0);
`ifdef KNN_VOTE_EN
        chk("rst.class", class_out, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.ready", in_ready, 0);

        // Small stream with a duplicate distance
        do_start(1'b0);
        send(32'd20, 3'd1, 1'b0);
        chk("t1.lat1", distance_sorted[W-1:0], 32'd20);
        chk("t1.cnt1", count, 1);
        send(32'd5, 3'd2, 1'b0);
        send(32'd90, 3'd3, 1'b0);
        send(32'd5, 3'd4, 1'b0);
        chk("t1.notyet", valid_sort, 0);
        send(32'd33, 3'd5, 1'b1);
        chk("t1.ready", in_ready, 0);
        wait_valid("t1", done_lat(5));
        check_list("t1");

        // 64 random samples, labels by 20-wide bands
        do_start(1'b0);
        for (int i = 0; i < 64; i++) begin
            r = W'($urandom_range(100, 0));
            send(r, TW'(r / 20), i == 63);
        end
        wait_valid("t2", done_lat(K));
        check_list("t2");

        // Full list: drop 9, then 0 displaces 8
        do_start(1'b0);
        for (int i = 1; i <= 8; i++) send(W'(i), TW'(i % 8), 1'b0);
        send(32'd9, 3'd1, 1'b0);
        chk("t3.drop.cnt", count, 8);
        chk("t3.drop.s7", distance_sorted[7*W +: W], 32'd8);
        send(32'd0, 3'd7, 1'b1);
        wait_valid("t3", done_lat(K));
        check_list("t3");

        // Restart mid-stream; the start-cycle sample must be ignored
        do_start(1'b0);
        send(32'd11, 3'd1, 1'b0);
        send(32'd12, 3'd2, 1'b0);
        send(32'd13, 3'd3, 1'b0);
        do_start(1'b1);
        send(32'hFFFF_FFFF, 3'd7, 1'b0);
        chk("t5.maxd.cnt", count, 1);
        send(32'd3, 3'd4, 1'b1);
        wait_valid("t5", done_lat(2));
        check_list("t5");

`ifdef KNN_VOTE_EN
        // Vote tie between classes 2 and 3: nearest wins
        do_start(1'b0);
        send(32'd10, 3'd2, 1'b0);
        send(32'd20, 3'd2, 1'b0);
        send(32'd30, 3'd3, 1'b0);
        send(32'd40, 3'd3, 1'b0);
        send(32'd50, 3'd1, 1'b1);
        wait_valid("vote", 6);
        chk("vote.class", class_out, 2);
        check_list("vote");
`endif

        // Asynchronous reset during FILL
        do_start(1'b0);
        send(32'd4, 3'd1, 1'b0);
        send(32'd2, 3'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.dist", distance_sorted, {(W*K){1'b1}});
        chk("arst.type", type_sorted, 0);
        chk("arst.count", count, 0);
        chk("arst.ready", in_ready, 0);
        chk("arst.valid", valid_sort, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst.idle.ready", in_ready, 0);
        do_start(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
